// File: rtl/systolic_feed_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_feed_ctrl
//
// Sequencer for an N x N output-stationary systolic array. A tile runs
// IDLE -> CLR -> FEED -> DRAIN -> DONE -> IDLE. CLR clears the PE accumulators,
// FEED issues the skewed per-row / per-column operand strobes (row i and
// column j start i resp. j cycles late), DRAIN keeps the array shifting until
// the last product has reached PE(N-1,N-1), and DONE pulses once.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   start_i      begin a tile (only looked at in IDLE)
//   hold_i       freeze sequencing in FEED/DRAIN
//   busy_o       high in CLR, FEED and DRAIN
//   done_o       one-cycle pulse in DONE
//   acc_clr_o    clear all PE accumulators (CLR only)
//   array_en_o   PE shift/accumulate enable
//   a_valid_o    bit i: row i A-operand injected this cycle
//   a_k_o        packed k index per row, row 0 in the LSBs
//   b_valid_o    bit j: column j B-operand injected this cycle
//   b_k_o        packed k index per column, column 0 in the LSBs
// -----------------------------------------------------------------------------
module systolic_feed_ctrl #(
   parameter int N      = 4,
   parameter int K      = 4,
   parameter int PE_LAT = 1,
   localparam int KW    = (K > 1) ? $clog2(K) : 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic            hold_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            acc_clr_o,
   output logic            array_en_o,
   output logic [N-1:0]    a_valid_o,
   output logic [N*KW-1:0] a_k_o,
   output logic [N-1:0]    b_valid_o,
   output logic [N*KW-1:0] b_k_o
);

   localparam int FEED_LEN  = K + N - 1;
   localparam int DRAIN_LEN = N - 1 + PE_LAT;
   localparam int T_MAX     = (FEED_LEN > DRAIN_LEN) ? FEED_LEN : DRAIN_LEN;
   localparam int TW        = $clog2(T_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_FEED,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   t_q, t_d;

   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            acc_clr_q, acc_clr_d;
   logic            en_q, en_d;
   logic [N-1:0]    lane_vld_q, lane_vld_d;
   logic [N*KW-1:0] lane_k_q, lane_k_d;
   logic            frz;
   int              ti;

   // Next state and cycle counter; the counter restarts on every state change.
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_CLR;
               t_d     = '0;
            end
         end
         S_CLR: begin
            state_d = S_FEED;
            t_d     = '0;
         end
         S_FEED: begin
            if (!hold_i) begin
               if (t_q == TW'(FEED_LEN - 1)) begin
                  state_d = S_DRAIN;
                  t_d     = '0;
               end else begin
                  t_d = t_q + TW'(1);
               end
            end
         end
         S_DRAIN: begin
            if (!hold_i) begin
               if (t_q == TW'(DRAIN_LEN - 1)) begin
                  state_d = S_DONE;
                  t_d     = '0;
               end else begin
                  t_d = t_q + TW'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            t_d     = '0;
         end
         default: begin
            state_d = S_IDLE;
            t_d     = '0;
         end
      endcase
   end

   // Output decode of the upcoming (state, t), so the outputs come straight
   // from flops. Rows and columns follow the same skew, so one lane vector
   // feeds both the A and B strobes.
   always_comb begin
      busy_d     = 1'b0;
      done_d     = 1'b0;
      acc_clr_d  = 1'b0;
      en_d       = 1'b0;
      lane_vld_d = '0;
      lane_k_d   = '0;
      ti         = 0;
      unique case (state_d)
         S_CLR: begin
            busy_d    = 1'b1;
            acc_clr_d = 1'b1;
         end
         S_FEED: begin
            busy_d = 1'b1;
            en_d   = 1'b1;
            for (int i = 0; i < N; i++) begin
               ti = int'(t_d) - i;
               if (ti >= 0 && ti < K) begin
                  lane_vld_d[i]           = 1'b1;
                  lane_k_d[i*KW +: KW]    = KW'(ti);
               end
            end
         end
         S_DRAIN: begin
            busy_d = 1'b1;
            en_d   = 1'b1;
         end
         S_DONE: begin
            done_d = 1'b1;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         t_q        <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         acc_clr_q  <= 1'b0;
         en_q       <= 1'b0;
         lane_vld_q <= '0;
         lane_k_q   <= '0;
      end else begin
         state_q    <= state_d;
         t_q        <= t_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         acc_clr_q  <= acc_clr_d;
         en_q       <= en_d;
         lane_vld_q <= lane_vld_d;
         lane_k_q   <= lane_k_d;
      end
   end

   // A hold cycle must suppress the strobes of that same cycle; the frozen
   // state then re-presents them once hold drops, so nothing is lost or doubled.
   assign frz = hold_i && ((state_q == S_FEED) || (state_q == S_DRAIN));

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign acc_clr_o  = acc_clr_q;
   assign array_en_o = en_q & ~frz;
   assign a_valid_o  = lane_vld_q & {N{~frz}};
   assign b_valid_o  = lane_vld_q & {N{~frz}};
   assign a_k_o      = lane_k_q;
   assign b_k_o      = lane_k_q;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
module tb_systolic_feed_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic s0, h0, s1, h1;

   // Instance 0: N=4, K=4, PE_LAT=1 (KW=2)
   logic       busy0, done0, clr0, en0;
   logic [3:0] av0, bv0;
   logic [7:0] ak0, bk0;
   // Instance 1: N=2, K=8, PE_LAT=3 (KW=3)
   logic       busy1, done1, clr1, en1;
   logic [1:0] av1, bv1;
   logic [5:0] ak1, bk1;

   systolic_feed_ctrl #(.N(4), .K(4), .PE_LAT(1)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(s0), .hold_i(h0),
      .busy_o(busy0), .done_o(done0), .acc_clr_o(clr0), .array_en_o(en0),
      .a_valid_o(av0), .a_k_o(ak0), .b_valid_o(bv0), .b_k_o(bk0));

   systolic_feed_ctrl #(.N(2), .K(8), .PE_LAT(3)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(s1), .hold_i(h1),
      .busy_o(busy1), .done_o(done1), .acc_clr_o(clr1), .array_en_o(en1),
      .a_valid_o(av1), .a_k_o(ak1), .b_valid_o(bv1), .b_k_o(bk1));

   int checks   = 0;
   int failures = 0;

   // Reference model: m_e counts non-held tile cycles since start was taken
   // (-1 = idle, 0 = clear cycle, then FEED cycles, DRAIN cycles, done cycle).
   int pn[2] = '{4, 2};
   int pk[2] = '{4, 8};
   int pp[2] = '{1, 3};
   int m_e[2] = '{-1, -1};
   int nxa[2][4];
   int nxb[2][4];
   int done_cnt[2] = '{0, 0};
   logic last_done[2];

   function automatic int kw_of(input int k);
      int w;
      w = 0;
      while ((1 << w) < k) w++;
      return (w == 0) ? 1 : w;
   endfunction

   function automatic int tile_len(input int sel);
      return 1 + (pk[sel] + pn[sel] - 1) + (pn[sel] - 1 + pp[sel]);
   endfunction

   task automatic clear_track(input int sel);
      for (int i = 0; i < 4; i++) begin
         nxa[sel][i] = 0;
         nxb[sel][i] = 0;
      end
   endtask

   // Expected outputs: ctl = {busy, done, acc_clr, array_en}.
   task automatic model_out(input int sel, input bit h, output logic [3:0] ctl,
                            output logic [31:0] v, output logic [31:0] kx);
      int n, k, f, d, e, kw, t;
      n = pn[sel]; k = pk[sel]; e = m_e[sel];
      f = k + n - 1; d = n - 1 + pp[sel]; kw = kw_of(k);
      ctl = 4'b0000; v = '0; kx = '0;
      if (e == 0) begin
         ctl = 4'b1010;
      end else if (e >= 1 && e <= f) begin
         ctl = {3'b100, ~h};
         t = e - 1;
         for (int i = 0; i < n; i++) begin
            if (t >= i && t <= i + k - 1) begin
               v[i] = ~h;
               kx   = kx | (32'(t - i) << (i * kw));
            end
         end
      end else if (e > f && e <= f + d) begin
         ctl = {3'b100, ~h};
      end else if (e == f + d + 1) begin
         ctl = 4'b0100;
      end
   endtask

   task automatic model_step(input int sel, input bit s, input bit h);
      int last;
      last = pk[sel] + pn[sel] - 1 + pn[sel] - 1 + pp[sel];
      if (m_e[sel] < 0) begin
         if (s) m_e[sel] = 0;
      end else if (m_e[sel] == 0) begin
         m_e[sel] = 1;
      end else if (m_e[sel] <= last) begin
         if (!h) m_e[sel] = m_e[sel] + 1;
      end else begin
         m_e[sel] = -1;
      end
   endtask

   task automatic check_inst(input int sel, input bit h);
      logic [3:0]  ectl, octl;
      logic [31:0] ev, ek, oav, obv, oak, obk;
      int n, k, kw, kk, f;
      bit infeed;
      n = pn[sel]; k = pk[sel]; kw = kw_of(k); f = k + n - 1;
      model_out(sel, h, ectl, ev, ek);
      if (sel == 0) begin
         octl = {busy0, done0, clr0, en0};
         oav = 32'(av0); obv = 32'(bv0); oak = 32'(ak0); obk = 32'(bk0);
      end else begin
         octl = {busy1, done1, clr1, en1};
         oav = 32'(av1); obv = 32'(bv1); oak = 32'(ak1); obk = 32'(bk1);
      end
      checks += 5;
      assert (octl === ectl) else begin
         failures++; $error("FAIL ctl sel=%0d e=%0d obs=%b exp=%b", sel, m_e[sel], octl, ectl);
      end
      assert (oav === ev) else begin
         failures++; $error("FAIL a_valid sel=%0d e=%0d obs=%h exp=%h", sel, m_e[sel], oav, ev);
      end
      assert (obv === ev) else begin
         failures++; $error("FAIL b_valid sel=%0d e=%0d obs=%h exp=%h", sel, m_e[sel], obv, ev);
      end
      assert (oak === ek) else begin
         failures++; $error("FAIL a_k sel=%0d e=%0d obs=%h exp=%h", sel, m_e[sel], oak, ek);
      end
      assert (obk === ek) else begin
         failures++; $error("FAIL b_k sel=%0d e=%0d obs=%h exp=%h", sel, m_e[sel], obk, ek);
      end
      // Strobe integrity: each lane sees k = 0..K-1 once each, ascending, in FEED only.
      infeed = (m_e[sel] >= 1 && m_e[sel] <= f);
      for (int i = 0; i < n; i++) begin
         if (oav[i]) begin
            kk = int'((oak >> (i * kw)) & ((32'd1 << kw) - 32'd1));
            checks++;
            assert (((infeed && nxa[sel][i] < k) ? kk : -1) === nxa[sel][i]) else begin
               failures++; $error("FAIL a_seq sel=%0d row=%0d obs=%0d exp=%0d", sel, i, kk, nxa[sel][i]);
            end
            nxa[sel][i]++;
         end
         if (obv[i]) begin
            kk = int'((obk >> (i * kw)) & ((32'd1 << kw) - 32'd1));
            checks++;
            assert (((infeed && nxb[sel][i] < k) ? kk : -1) === nxb[sel][i]) else begin
               failures++; $error("FAIL b_seq sel=%0d col=%0d obs=%0d exp=%0d", sel, i, kk, nxb[sel][i]);
            end
            nxb[sel][i]++;
         end
      end
      last_done[sel] = octl[2];
      if (octl[2]) begin
         done_cnt[sel]++;
         for (int i = 0; i < n; i++) begin
            checks += 2;
            assert (nxa[sel][i] === k) else begin
               failures++; $error("FAIL a_count sel=%0d row=%0d obs=%0d exp=%0d", sel, i, nxa[sel][i], k);
            end
            assert (nxb[sel][i] === k) else begin
               failures++; $error("FAIL b_count sel=%0d col=%0d obs=%0d exp=%0d", sel, i, nxb[sel][i], k);
            end
         end
         clear_track(sel);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, check, then step the model.
   task automatic cyc(input bit a0, input bit b0, input bit a1, input bit b1);
      @(negedge clk);
      s0 = a0; h0 = b0; s1 = a1; h1 = b1;
      #1;
      check_inst(0, b0);
      check_inst(1, b1);
      @(posedge clk);
      if (rst_n) begin
         model_step(0, a0, b0);
         model_step(1, a1, b1);
      end
   endtask

   task automatic cyc_sel(input int sel, input bit s, input bit h);
      if (sel == 0) cyc(s, h, 1'b0, 1'b0);
      else          cyc(1'b0, 1'b0, s, h);
   endtask

   // Run one tile on one instance. Hold windows are given in cycles counted
   // from the start cycle (c=1 is the clear cycle). Returns c of the done pulse.
   task automatic run_tile(input int sel, input int ha, input int hl, input int hb,
                           input int hbl, input bit busy_start, output int lat);
      int  exp_c;
      bit  h, s;
      exp_c = tile_len(sel) + 1 + hl + hbl;
      lat = -1;
      cyc_sel(sel, 1'b1, 1'b0);
      for (int c = 1; c < 200; c++) begin
         h = (c >= ha && c < ha + hl) || (c >= hb && c < hb + hbl);
         s = busy_start && (c == 4 || c == exp_c);
         cyc_sel(sel, s, h);
         if (last_done[sel]) begin
            lat = c;
            break;
         end
      end
      checks++;
      assert (lat === exp_c) else begin
         failures++; $error("FAIL latency sel=%0d obs=%0d exp=%0d", sel, lat, exp_c);
      end
   endtask

   int lat;
   int dc;

   initial begin
      clear_track(0);
      clear_track(1);
      last_done[0] = 1'b0;
      last_done[1] = 1'b0;
      rst_n = 1'b0;
      s0 = 1'b0; h0 = 1'b0; s1 = 1'b0; h1 = 1'b0;
      #1;
      check_inst(0, 1'b0);
      check_inst(1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic tile, then holds in FEED (t=3, 3 cycles) and in DRAIN (2 cycles).
      run_tile(0, 0, 0, 0, 0, 1'b0, lat);
      run_tile(0, 5, 3, 13, 2, 1'b0, lat);

      // Start during FEED and during DONE is ignored; start right after DONE runs.
      dc = done_cnt[0];
      run_tile(0, 0, 0, 0, 0, 1'b1, lat);
      run_tile(0, 0, 0, 0, 0, 1'b0, lat);
      repeat (20) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      assert ((done_cnt[0] - dc) === 2) else begin
         failures++; $error("FAIL done_count obs=%0d exp=2", done_cnt[0] - dc);
      end

      // Asynchronous reset during FEED t=4 of a tile.
      dc = done_cnt[0];
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      m_e[0] = -1;
      m_e[1] = -1;
      clear_track(0);
      clear_track(1);
      #1;
      check_inst(0, 1'b0);
      check_inst(1, 1'b0);
      repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (15) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      assert ((done_cnt[0] - dc) === 0) else begin
         failures++; $error("FAIL abort_done obs=%0d exp=0", done_cnt[0] - dc);
      end
      run_tile(0, 0, 0, 0, 0, 1'b0, lat);

      // Second parameter set: basic tile and a hold inside DRAIN.
      run_tile(1, 0, 0, 0, 0, 1'b0, lat);
      run_tile(1, 4, 2, 13, 3, 1'b0, lat);

      // Randomized start/hold on both instances against the model.
      for (int r = 0; r < 3000; r++) begin
         cyc($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
